// File: rtl/btn_cond_if.sv
// Button conditioner bus: raw board inputs in, debounced level and edge strobes out.
// The master side drives the raw inputs; the conditioner is the slave.
interface btn_cond_if #(
  parameter int N = 2
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic [N-1:0] btn_rel;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_rel
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_rel
  );
endinterface

// File: rtl/btn_cond.sv
// Per-channel push-button conditioner.
// Each channel has a 2-flop synchroniser, then a debounce FSM that emits clean levels plus press/release strobes.
module btn_cond #(
  parameter int N         = 2,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  btn_cond_if.slave   bus
);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0] s1_q, s1_d;
  logic [N-1:0] s2_q, s2_d;
  logic [N-1:0] level_vec, pulse_vec, rel_vec;

  always_comb begin
    s1_d = bus.btn_raw;
    s2_d = s1_q;
  end

  // The synchroniser is cleared too, so a button held through reset looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             rel_q, rel_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        S_LOW: begin
          if (s2_q[gi]) begin
            state_d = S_RISE;
            cnt_d   = '0;
          end
        end
        S_RISE: begin
          if (!s2_q[gi]) begin
            state_d = S_LOW;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HIGH;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (!s2_q[gi]) begin
            state_d = S_FALL;
            cnt_d   = '0;
          end
        end
        S_FALL: begin
          if (s2_q[gi]) begin
            state_d = S_HIGH;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_LOW;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= S_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
        rel_q   <= rel_d;
      end
    end

    assign level_vec[gi] = level_q;
    assign pulse_vec[gi] = pulse_q;
    assign rel_vec[gi]   = rel_q;
  end

  assign bus.btn_level = level_vec;
  assign bus.btn_pulse = pulse_vec;
  assign bus.btn_rel   = rel_vec;

endmodule
